fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch front end that produces the F-stage values captured by the IF/ID pipeline register: instruction word, PC and PC+4. It owns the PC register and runs a req/ack handshake to instruction memory. Memory latency can be single-cycle (combinational ack) or multi-cycle. A one-entry skid buffer absorbs a fetch that completes while decode is stalled, and a drain state discards in-flight fetches after a control-flow redirect.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instruction words
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction word driven while no valid instruction is held

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
stall_f  in  1  1 = IF/ID register is holding this cycle; slot not consumed
redirect  in  1  control-flow change resolved downstream (branch/jump taken)
redirect_pc  in  DATA_WIDTH  redirect target
imem_req  out  1  fetch request
imem_addr  out  DATA_WIDTH  fetch address; stable while imem_req=1 until ack
imem_ack  in  1  memory completes request this cycle (may equal cycle of req)
imem_rdata  in  DATA_WIDTH  instruction word, valid when imem_ack=1
instr_f  out  DATA_WIDTH  instruction to IF/ID register
pc_f  out  DATA_WIDTH  PC of instr_f
pc_plus_f  out  DATA_WIDTH  pc_f + 4
fetch_valid  out  1  slot holds a real instruction; 0 = bubble

Behaviour:
- Reset (async, immediate): state IDLE, pc=RESET_PC, fetch_valid=0, instr_f=NOP_INSTR, pc_f=RESET_PC, pc_plus_f=RESET_PC+4, skid empty, imem_req=0, imem_addr=RESET_PC. Any in-flight transaction is abandoned.
- States: IDLE, RUN, DRAIN.
  - IDLE: one cycle after reset deassertion, then unconditionally to RUN.
  - RUN: imem_req = !skid_valid; imem_addr = pc.
  - DRAIN: imem_req=1 with imem_addr = latched old address; imem_ack returns to RUN with the data discarded.
- Slot: instr_f/pc_f/pc_plus_f/fetch_valid, all registered outputs.
  - Slot is consumed on any cycle with fetch_valid=1 and stall_f=0.
  - When the slot is empty or consumed, it loads from the skid if the skid is valid (skid empties). Otherwise it loads the ack data (if any). Otherwise fetch_valid<=0 and instr_f<=NOP_INSTR.
- Ack in RUN: pc<=pc+4. Data goes to the slot if the slot is free this cycle and the skid is empty; otherwise it goes to the skid.
  - Skid cannot overflow: no request is launched while skid_valid=1.
- Handshake rule: once imem_req rises, imem_req and imem_addr stay constant until the ack cycle.
  - A new request may start the cycle after an ack, or in the same cycle if ack is combinational.
- Latency: with ack tied 1 and no stall, the first fetch_valid=1 occurs 2 cycles after reset release. Throughput is then 1 instruction/cycle.
- Redirect (priority over stall_f and ack data):
  - Next cycle: fetch_valid=0, instr_f=NOP_INSTR, skid cleared.
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - If a request is outstanding and there is no ack this cycle: go to DRAIN, keeping the old address on the bus.
  - If ack arrives in the same cycle: discard the data, stay RUN, and request the new pc next cycle.
- Redirect while in DRAIN: update the pending pc only; remain in DRAIN until ack.
- Arithmetic: pc+4 and pc_plus_f wrap modulo 2^DATA_WIDTH (0xFFFF_FFFC -> 0x0000_0000). No overflow flag.
- stall_f only gates consumption. It never forces imem_req low directly; only a full skid does.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetched (32 bits) and perf_flushed (32 bits), both reset to 0.
  - perf_fetched +1 per consumed slot.
  - perf_flushed +1 per discarded instruction: each valid slot entry and each valid skid entry cleared by redirect, plus each drained ack.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. RESET_PC=0, imem_ack tied 1, imem_rdata=addr^32'hA5A5_0000 -> fetch_valid rises at cycle 2 after reset release; pc_f = 0,4,8,12 on consecutive cycles; pc_plus_f = pc_f+4.
2. Ack tied 1, stall_f=1 for 3 cycles while the slot holds pc 8 -> slot holds 8, skid captures 12, imem_req=0 on the 2nd and 3rd stalled cycles; on release the slot shows 12 then 16, with no instruction lost or duplicated.
3. redirect=1 with redirect_pc=0x100 in the same cycle as an ack for 0x14 -> next cycle fetch_valid=0, instr_f=0x13, imem_addr=0x100; the cycle after, pc_f=0x100.
4. Ack 3 cycles after req; redirect to 0x200 in the first wait cycle -> imem_addr stays at the old address with req=1 until ack, the data is discarded and never appears on instr_f, then req is raised for 0x200.
5. redirect_pc=0x103 -> fetch address 0x100. Redirect to 0xFFFF_FFFC -> pc_f=0xFFFF_FFFC, pc_plus_f=0, next pc_f=0x0.
6. Assert rst mid-DRAIN (asynchronous, between clock edges) -> imem_req=0, fetch_valid=0, pc_f=RESET_PC immediately; after release, a normal restart as in test 1.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PC, imem req/ack handshake, one-entry skid and redirect drain.
// Optional FETCH_PERF_EN adds perf_fetched/perf_flushed counters.
module fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_f,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr_f,
  output logic [DATA_WIDTH-1:0] pc_f,
  output logic [DATA_WIDTH-1:0] pc_plus_f,
  output logic                  fetch_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushed
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] pc, drain_addr, skid_instr, skid_pc, target;
  logic skid_valid, accept, consume, slot_free, to_drain;
  assign imem_req = state == RUN ? !skid_valid : state == DRAIN;
  assign imem_addr = state == DRAIN ? drain_addr : pc;
  assign accept = state == RUN && imem_req && imem_ack;
  assign consume = fetch_valid && !stall_f;
  assign slot_free = !fetch_valid || consume;
  assign target = redirect_pc & ~DATA_WIDTH'(3);
  assign to_drain = state == RUN && redirect && imem_req && !imem_ack;
  always_comb begin
    state_nx = state == IDLE ? RUN :
               state == RUN  ? (to_drain ? DRAIN : RUN) :
               (imem_ack ? RUN : DRAIN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      drain_addr <= RESET_PC;
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc <= RESET_PC;
      fetch_valid <= 1'b0;
      instr_f <= NOP_INSTR;
      pc_f <= RESET_PC;
      pc_plus_f <= RESET_PC + DATA_WIDTH'(4);
    end else begin
      state <= state_nx;
      if (redirect) pc <= target;
      else if (accept) pc <= pc + DATA_WIDTH'(4);
      if (to_drain) drain_addr <= pc;
      // redirect wins over stall and over any data arriving this cycle
      if (redirect) begin
        fetch_valid <= 1'b0;
        instr_f <= NOP_INSTR;
        skid_valid <= 1'b0;
      end else if (slot_free) begin
        if (skid_valid) begin
          fetch_valid <= 1'b1;
          instr_f <= skid_instr;
          pc_f <= skid_pc;
          pc_plus_f <= skid_pc + DATA_WIDTH'(4);
          skid_valid <= 1'b0;
        end else if (accept) begin
          fetch_valid <= 1'b1;
          instr_f <= imem_rdata;
          pc_f <= pc;
          pc_plus_f <= pc + DATA_WIDTH'(4);
        end else begin
          fetch_valid <= 1'b0;
          instr_f <= NOP_INSTR;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc <= pc;
      end
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(consume);
      perf_flushed <= perf_flushed + 32'(redirect && fetch_valid && !consume)
                    + 32'(redirect && skid_valid)
                    + 32'(imem_req && imem_ack && (redirect || state == DRAIN));
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors plus randomized run against a program-order stream model.
module tb_fetch_stage;
  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1, stall_f = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic imem_req, imem_ack, fetch_valid;
  logic [31:0] imem_addr, imem_rdata, instr_f, pc_f, pc_plus_f;
  int checks = 0, failures = 0, mode = 0, wait_cnt = 0, consumed = 0;
  bit mon_en = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_f(instr_f),
    .pc_f(pc_f), .pc_plus_f(pc_plus_f), .fetch_valid(fetch_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // memory: mode 0 = combinational ack, 1 = random latency 0..3, 2 = ack 3 cycles after req
  assign imem_ack = imem_req && (mode == 0 || wait_cnt == 0);
  assign imem_rdata = imem_addr ^ K;
  always @(posedge clk)
    if (!imem_req || imem_ack) wait_cnt <= mode == 2 ? 3 : mode == 1 ? int'($urandom_range(0, 3)) : 0;
    else wait_cnt <= wait_cnt - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall_f = 1'b0;
    redirect = 1'b0;
    step();
    chk("rst_req", imem_req, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_instr", instr_f, NOP);
    chk("rst_pc", pc_f, 0);
    chk("rst_pcp", pc_plus_f, 4);
    chk("rst_addr", imem_addr, 0);
    rst = 1'b0;
  endtask

  // reference: consumed slots must follow program order, restarting at each redirect target
  logic [31:0] exp_pc = '0, prev_addr = '0;
  bit prev_pend = 1'b0, prev_redir = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = '0;
      prev_pend = 1'b0;
      prev_redir = 1'b0;
    end else if (mon_en) begin
      if (prev_pend) begin
        chk("hold_req", imem_req, 1);
        chk("hold_addr", imem_addr, prev_addr);
      end
      if (prev_redir) chk("redir_bubble", fetch_valid, 0);
      if (fetch_valid && !stall_f) begin
        chk("seq_pc", pc_f, exp_pc);
        chk("seq_instr", instr_f, exp_pc ^ K);
        chk("seq_pcp", pc_plus_f, exp_pc + 4);
        exp_pc += 4;
        consumed++;
      end
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      prev_redir = redirect;
    end
  end

  typedef struct {logic stall; logic fv; logic [31:0] pc; logic req;} vec_t;
  vec_t tbl[11];

  initial begin
    logic [31:0] old;
    tbl[0] = '{1'b0, 1'b0, 32'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'd0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 32'd0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 32'd4, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 32'd8, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 32'd8, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 32'd8, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 32'd8, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 32'd12, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 32'd16, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'd20, 1'b1};
    mode = 0;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("t12_fv[%0d]", k), fetch_valid, tbl[k].fv);
      chk($sformatf("t12_pc[%0d]", k), pc_f, tbl[k].pc);
      chk($sformatf("t12_pcp[%0d]", k), pc_plus_f, tbl[k].pc + 4);
      chk($sformatf("t12_instr[%0d]", k), instr_f, tbl[k].fv ? tbl[k].pc ^ K : NOP);
      chk($sformatf("t12_req[%0d]", k), imem_req, tbl[k].req);
      stall_f = tbl[k].stall;
      step();
    end
    // redirect in the same cycle as an ack for 0x14
    do_reset();
    for (int i = 0; i < 20 && imem_addr != 32'h14; i++) step();
    chk("t3_reach", imem_addr, 32'h14);
    chk("t3_ack", imem_ack, 1);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("t3_fv", fetch_valid, 0);
    chk("t3_instr", instr_f, NOP);
    chk("t3_addr", imem_addr, 32'h100);
    step();
    chk("t3_fv2", fetch_valid, 1);
    chk("t3_pc", pc_f, 32'h100);
    chk("t3_instr2", instr_f, 32'h100 ^ K);
    // 3-cycle latency, redirect during the first wait cycle
    mode = 2;
    step();
    chk("t4_req", imem_req, 1);
    chk("t4_wait", imem_ack, 0);
    old = imem_addr;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_dreq", imem_req, 1);
      chk("t4_daddr", imem_addr, old);
      chk("t4_dfv", fetch_valid, 0);
      step();
    end
    chk("t4_req2", imem_req, 1);
    chk("t4_addr2", imem_addr, 32'h200);
    chk("t4_fv2", fetch_valid, 0);
    for (int i = 0; i < 10 && !fetch_valid; i++) step();
    chk("t4_fv3", fetch_valid, 1);
    chk("t4_pc", pc_f, 32'h200);
    chk("t4_instr", instr_f, 32'h200 ^ K);
    // alignment and wrap
    mode = 0;
    redirect = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    chk("t5_addr", imem_addr, 32'h100);
    chk("t5_fv", fetch_valid, 0);
    step();
    chk("t5_pc", pc_f, 32'h100);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("t5_waddr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t5_wfv", fetch_valid, 1);
    chk("t5_wpc", pc_f, 32'hFFFF_FFFC);
    chk("t5_wpcp", pc_plus_f, 32'h0);
    step();
    chk("t5_zpc", pc_f, 32'h0);
    chk("t5_zpcp", pc_plus_f, 32'h4);
    // async reset while draining
    mode = 2;
    step();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    chk("t6_drain_req", imem_req, 1);
    chk("t6_drain_ack", imem_ack, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_req", imem_req, 0);
    chk("t6_fv", fetch_valid, 0);
    chk("t6_pc", pc_f, 32'h0);
    chk("t6_pcp", pc_plus_f, 32'h4);
    chk("t6_instr", instr_f, NOP);
    chk("t6_addr", imem_addr, 32'h0);
    mode = 0;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t6_rfv[%0d]", k), fetch_valid, k >= 2);
      chk($sformatf("t6_rpc[%0d]", k), pc_f, k >= 2 ? 32'((k - 2) * 4) : 32'h0);
    end
    // randomized run against the stream model
    mode = 1;
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      stall_f = ($urandom % 4) == 0;
      redirect = ($urandom % 12) == 0;
      redirect_pc = ($urandom % 8) == 0 ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step();
    end
    mon_en = 1'b0;
    chk("rand_progress", consumed > 200, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
